// File: rtl/inta_sequencer.sv
// Acknowledge-cycle controller for an 8259A-style PIC: raises INT, runs the
// two-pulse INTA sequence, owns the In-Service Register and EOI/AEOI handling.
module inta_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT_REQ,
    input  logic [2:0] REQ_LEVEL,
    input  logic       INTA_N,
    input  logic [4:0] VECTOR_BASE,
    input  logic       AEOI,
    input  logic       EOI,
    input  logic       EOI_SPECIFIC,
    input  logic [2:0] EOI_LEVEL,
    output logic       INT,
    output logic [7:0] ISR,
    output logic [7:0] IRR_CLR,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   inta_prev_q;
    logic                   seen_high_q;
    logic                   sync_inta;
    logic                   inta_fall;
    logic                   inta_rise;
    logic [2:0]             lvl_q, lvl_d;
    logic                   valid_q, valid_d;
    logic                   isr_set, aeoi_clr;
    logic [3:0]             highest_isr;
    logic                   eligible;
    logic [7:0]             isr_d, irr_clr_d, data_out_d;
    logic                   int_d, busy_d, oe_d;

    function automatic logic [3:0] lowest_set(input logic [7:0] v);
        lowest_set = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

    // INTA_N synchronizer; fill_q marks when the chain holds real pin samples so
    // a pin held low through reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            fill_q      <= '0;
            inta_prev_q <= 1'b1;
            seen_high_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], INTA_N};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            inta_prev_q <= sync_inta;
            if (fill_q[SYNC_STAGES-1] && sync_inta) seen_high_q <= 1'b1;
        end
    end

    assign sync_inta   = sync_q[SYNC_STAGES-1];
    assign inta_fall   = seen_high_q && inta_prev_q && !sync_inta;
    assign inta_rise   = !inta_prev_q && sync_inta;
    assign highest_isr = lowest_set(ISR);
    assign eligible    = INT_REQ && ({1'b0, REQ_LEVEL} < highest_isr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lvl_q    <= 3'd0;
            valid_q  <= 1'b0;
            ISR      <= 8'h00;
            IRR_CLR  <= 8'h00;
            INT      <= 1'b0;
            BUSY     <= 1'b0;
            DATA_OE  <= 1'b0;
            DATA_OUT <= 8'h00;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            valid_q  <= valid_d;
            ISR      <= isr_d;
            IRR_CLR  <= irr_clr_d;
            INT      <= int_d;
            BUSY     <= busy_d;
            DATA_OE  <= oe_d;
            DATA_OUT <= data_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        valid_d  = valid_q;
        isr_set  = 1'b0;
        aeoi_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    lvl_d   = 3'(SPURIOUS_LEVEL);
                    valid_d = 1'b0;
                end else if (eligible) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    lvl_d   = REQ_LEVEL;
                    valid_d = eligible;
                    isr_set = eligible;
                end else if (!eligible) begin
                    state_d = IDLE;
                end
            end
            ACK1:  if (inta_rise) state_d = WAIT2;
            WAIT2: if (inta_fall) state_d = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_d  = IDLE;
                    aeoi_clr = AEOI && valid_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clears (EOI, AEOI) apply before the acknowledge set, so a set wins.
        isr_d = ISR;
        if (EOI && (ISR != 8'h00)) begin
            if (EOI_SPECIFIC) isr_d[EOI_LEVEL]        = 1'b0;
            else              isr_d[highest_isr[2:0]] = 1'b0;
        end
        if (aeoi_clr) isr_d[lvl_q] = 1'b0;
        if (isr_set)  isr_d[lvl_d] = 1'b1;

        irr_clr_d  = isr_set ? (8'h01 << lvl_d) : 8'h00;
        int_d      = (state_d == ARMED);
        busy_d     = (state_d == ACK1) || (state_d == WAIT2) || (state_d == ACK2);
        oe_d       = (state_d == ACK2);
        data_out_d = oe_d ? {VECTOR_BASE, lvl_d} : 8'h00;
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed scenarios plus randomized acknowledge/EOI
// traffic checked against an ISR-level behavioural model.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       INT_REQ;
    logic [2:0] REQ_LEVEL;
    logic       INTA_N;
    logic [4:0] VECTOR_BASE;
    logic       AEOI;
    logic       EOI;
    logic       EOI_SPECIFIC;
    logic [2:0] EOI_LEVEL;
    logic       INT;
    logic [7:0] ISR;
    logic [7:0] IRR_CLR;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic       BUSY;

    int         n_pass = 0;
    int         n_total = 0;
    int         irr_cnt = 0;
    logic [7:0] irr_last = 8'h00;
    logic [7:0] m_isr = 8'h00;
    logic [7:0] last_vec = 8'h00;

    inta_sequencer #(.SYNC_STAGES(2), .SPURIOUS_LEVEL(7)) dut (
        .clk(clk), .rst_n(rst_n), .INT_REQ(INT_REQ), .REQ_LEVEL(REQ_LEVEL),
        .INTA_N(INTA_N), .VECTOR_BASE(VECTOR_BASE), .AEOI(AEOI), .EOI(EOI),
        .EOI_SPECIFIC(EOI_SPECIFIC), .EOI_LEVEL(EOI_LEVEL), .INT(INT), .ISR(ISR),
        .IRR_CLR(IRR_CLR), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    // Count every cycle in which an IRR clear pulse is visible.
    always @(negedge clk) begin
        if (IRR_CLR !== 8'h00) begin
            irr_cnt  = irr_cnt + 1;
            irr_last = IRR_CLR;
        end
    end

    function automatic int highest(input logic [7:0] v);
        highest = 8;
        for (int i = 7; i >= 0; i--) if (v[i]) highest = i;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full two-pulse acknowledge with model-predicted outcome.
    task automatic do_ack(input bit req, input logic [2:0] lvl, input logic [4:0] base, input bit aeoi);
        bit         valid;
        logic [2:0] elvl;
        logic [7:0] evec;
        logic [7:0] epulse;
        int         c0;
        INT_REQ = req; REQ_LEVEL = lvl; VECTOR_BASE = base; AEOI = aeoi;
        valid = req && (int'(lvl) < highest(m_isr));
        elvl  = valid ? lvl : 3'd7;
        evec  = {base, elvl};
        tick(3);
        n_total++;
        if (INT !== valid) $display("FAIL int_armed: got %b expected %b", INT, valid); else n_pass++;
        c0 = irr_cnt;
        INTA_N = 1'b0; tick(6);
        if (valid) m_isr[lvl] = 1'b1;
        n_total++;
        if (INT !== 1'b0) $display("FAIL int_ack1: got %b expected 0", INT); else n_pass++;
        n_total++;
        if (BUSY !== 1'b1) $display("FAIL busy_ack1: got %b expected 1", BUSY); else n_pass++;
        n_total++;
        if (ISR !== m_isr) $display("FAIL isr_ack1: got %h expected %h", ISR, m_isr); else n_pass++;
        INTA_N = 1'b1; tick(6);
        INTA_N = 1'b0; tick(6);
        n_total++;
        if (DATA_OE !== 1'b1) $display("FAIL oe_ack2: got %b expected 1", DATA_OE); else n_pass++;
        n_total++;
        if (DATA_OUT !== evec) $display("FAIL vector: got %h expected %h", DATA_OUT, evec); else n_pass++;
        last_vec = DATA_OUT;
        INT_REQ = 1'b0; INTA_N = 1'b1; tick(6);
        if (valid && aeoi) m_isr[lvl] = 1'b0;
        n_total++;
        if (ISR !== m_isr) $display("FAIL isr_end: got %h expected %h", ISR, m_isr); else n_pass++;
        n_total++;
        if ({BUSY, DATA_OE, DATA_OUT} !== 10'h000) $display("FAIL idle_outs: got %b/%b/%h expected 0/0/00", BUSY, DATA_OE, DATA_OUT); else n_pass++;
        n_total++;
        if ((irr_cnt - c0) != int'(valid)) $display("FAIL irr_pulses: got %0d expected %0d", irr_cnt - c0, valid); else n_pass++;
        if (valid) begin
            epulse = 8'h01 << lvl;
            n_total++;
            if (irr_last !== epulse) $display("FAIL irr_value: got %h expected %h", irr_last, epulse); else n_pass++;
        end
        AEOI = 1'b0;
    endtask

    task automatic do_eoi(input bit spec, input logic [2:0] lvl);
        EOI = 1'b1; EOI_SPECIFIC = spec; EOI_LEVEL = lvl;
        tick(1);
        EOI = 1'b0;
        if (m_isr != 8'h00) begin
            if (spec) m_isr[lvl] = 1'b0;
            else      m_isr[highest(m_isr)] = 1'b0;
        end
        tick(1);
        n_total++;
        if (ISR !== m_isr) $display("FAIL eoi_isr: got %h expected %h", ISR, m_isr); else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; INT_REQ = 1'b0; REQ_LEVEL = 3'd0; INTA_N = 1'b1; VECTOR_BASE = 5'h00;
        AEOI = 1'b0; EOI = 1'b0; EOI_SPECIFIC = 1'b0; EOI_LEVEL = 3'd0;
        tick(3);
        n_total++;
        if ({INT, BUSY, DATA_OE} !== 3'b000) $display("FAIL reset_ctl: got %b expected 000", {INT, BUSY, DATA_OE}); else n_pass++;
        n_total++;
        if ({ISR, IRR_CLR, DATA_OUT} !== 24'h0) $display("FAIL reset_bus: got %h expected 000000", {ISR, IRR_CLR, DATA_OUT}); else n_pass++;
        rst_n = 1'b1;
        m_isr = 8'h00;
        tick(5);
    endtask

    task automatic test_basic;
        do_ack(1'b1, 3'd3, 5'h08, 1'b0);
        n_total++;
        if (ISR !== 8'h08) $display("FAIL basic_isr: got %h expected 08", ISR); else n_pass++;
        n_total++;
        if (last_vec !== 8'h43) $display("FAIL basic_vec: got %h expected 43", last_vec); else n_pass++;
        do_eoi(1'b0, 3'd0);
    endtask

    task automatic test_nesting;
        do_ack(1'b1, 3'd2, 5'h10, 1'b0);
        INT_REQ = 1'b1; REQ_LEVEL = 3'd5;
        tick(5);
        n_total++;
        if (INT !== 1'b0) $display("FAIL nest_blocked: got %b expected 0", INT); else n_pass++;
        do_ack(1'b1, 3'd1, 5'h10, 1'b0);
        n_total++;
        if (ISR !== 8'h06) $display("FAIL nest_isr: got %h expected 06", ISR); else n_pass++;
        do_eoi(1'b0, 3'd0);
        do_eoi(1'b0, 3'd0);
    endtask

    task automatic test_aeoi;
        do_ack(1'b1, 3'd6, 5'h03, 1'b1);
        n_total++;
        if (ISR !== 8'h00) $display("FAIL aeoi_isr: got %h expected 00", ISR); else n_pass++;
    endtask

    task automatic test_eoi;
        do_ack(1'b1, 3'd6, 5'h02, 1'b0);
        do_ack(1'b1, 3'd0, 5'h02, 1'b0);
        n_total++;
        if (ISR !== 8'h41) $display("FAIL eoi_setup: got %h expected 41", ISR); else n_pass++;
        do_eoi(1'b0, 3'd3);
        n_total++;
        if (ISR !== 8'h40) $display("FAIL eoi_nonspec: got %h expected 40", ISR); else n_pass++;
        do_eoi(1'b1, 3'd6);
        n_total++;
        if (ISR !== 8'h00) $display("FAIL eoi_spec: got %h expected 00", ISR); else n_pass++;
        do_eoi(1'b0, 3'd0);
        n_total++;
        if (ISR !== 8'h00) $display("FAIL eoi_empty: got %h expected 00", ISR); else n_pass++;
    endtask

    task automatic test_spurious;
        int c0;
        INT_REQ = 1'b1; REQ_LEVEL = 3'd4;
        tick(4);
        n_total++;
        if (INT !== 1'b1) $display("FAIL spur_raise: got %b expected 1", INT); else n_pass++;
        INT_REQ = 1'b0;
        tick(3);
        n_total++;
        if (INT !== 1'b0) $display("FAIL spur_drop: got %b expected 0", INT); else n_pass++;
        c0 = irr_cnt;
        do_ack(1'b0, 3'd4, 5'h1f, 1'b0);
        n_total++;
        if (last_vec !== 8'hff) $display("FAIL spur_vec: got %h expected ff", last_vec); else n_pass++;
        n_total++;
        if (irr_cnt != c0 || ISR !== 8'h00) $display("FAIL spur_side: got irr %0d isr %h expected 0 00", irr_cnt - c0, ISR); else n_pass++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0)
                do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            else
                do_ack(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        while (m_isr != 8'h00) do_eoi(1'b0, 3'd0);
    endtask

    task automatic test_reset_wait2;
        INT_REQ = 1'b1; REQ_LEVEL = 3'd2; VECTOR_BASE = 5'h0a;
        tick(3);
        INTA_N = 1'b0; tick(6);
        INTA_N = 1'b1; tick(6);
        n_total++;
        if ({BUSY, ISR} !== 9'h104) $display("FAIL wait2_setup: got %b/%h expected 1/04", BUSY, ISR); else n_pass++;
        INTA_N = 1'b0; INT_REQ = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if ({INT, BUSY, DATA_OE, ISR, IRR_CLR, DATA_OUT} !== 27'h0)
            $display("FAIL reset_async: got %h expected 0", {INT, BUSY, DATA_OE, ISR, IRR_CLR, DATA_OUT});
        else n_pass++;
        m_isr = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        n_total++;
        if ({BUSY, DATA_OE, ISR} !== 10'h000) $display("FAIL held_low: got %b/%b/%h expected 0/0/00", BUSY, DATA_OE, ISR); else n_pass++;
        INTA_N = 1'b1;
        tick(6);
        do_ack(1'b1, 3'd5, 5'h0a, 1'b0);
        n_total++;
        if (ISR !== 8'h20) $display("FAIL fresh_ack: got %h expected 20", ISR); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_nesting;
        test_aeoi;
        test_eoi;
        test_spurious;
        test_random;
        test_reset_wait2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Acknowledge-cycle controller downstream of the priority resolver in the 8259A PIC.
- Takes the resolver's pending-request indication and winning level, raises INT to the CPU, and runs the two-pulse 8086-mode INTA sequence.
- Owns the In-Service Register: sets ISR and pulses IRR clear on the first INTA, drives the interrupt vector on the second, and handles EOI/AEOI.

Parameters:
SYNC_STAGES, 2, flops in INTA_N synchronizer (minimum 2)
SPURIOUS_LEVEL, 7, level reported in the vector when an acknowledge finds no valid request

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
INT_REQ  in  1  resolver: unmasked request pending
REQ_LEVEL  in  3  resolver: highest-priority pending level, valid when INT_REQ=1
INTA_N  in  1  CPU acknowledge, active low, asynchronous to clk
VECTOR_BASE  in  5  ICW2 T7..T3
AEOI  in  1  automatic EOI mode (ICW4)
EOI  in  1  one-cycle EOI command pulse (OCW2 decode)
EOI_SPECIFIC  in  1  1=specific EOI, 0=non-specific
EOI_LEVEL  in  3  level for specific EOI
INT  out  1  interrupt to CPU
ISR  out  8  In-Service Register
IRR_CLR  out  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
DATA_OUT  out  8  vector byte
DATA_OE  out  1  data-bus drive enable
BUSY  out  1  acknowledge in progress; resolver must hold its result

Behaviour:
- Fixed priority: level 0 highest. HIGHEST_ISR is the lowest set ISR index; 8 when ISR=0.
- Eligible = INT_REQ && (REQ_LEVEL < HIGHEST_ISR).
- INTA_N passes through a SYNC_STAGES flop chain, then edge detection on the synchronized value. Actions occur SYNC_STAGES+1 clocks after the pin edge.
- States:
  - IDLE: goes to ARMED when eligible.
  - ARMED: INT=1. Returns to IDLE if eligible drops before an INTA fall.
  - ARMED + INTA fall: latch LVL=REQ_LEVEL and VALID=eligible, then go to ACK1.
  - IDLE + INTA fall: latch LVL=SPURIOUS_LEVEL and VALID=0, then go to ACK1.
  - ACK1: on INTA rise, go to WAIT2.
  - WAIT2: on INTA fall, go to ACK2.
  - ACK2: DATA_OE=1. On INTA rise, go to IDLE.
- Entry to ACK1 when VALID=1: in the same cycle, ISR[LVL]<=1 and IRR_CLR[LVL] pulses for exactly one cycle.
- VALID=0 (spurious): ISR and IRR_CLR are untouched; the vector still uses LVL.
- INT is registered and equals (state==ARMED). It drops on the cycle ACK1 is entered.
- BUSY=1 in ACK1, WAIT2 and ACK2.
- DATA_OUT = {VECTOR_BASE, LVL} while DATA_OE=1; otherwise 8'h00.
- AEOI=1 and VALID=1: ISR[LVL] clears on the ACK2->IDLE transition.
- EOI pulse:
  - Specific: clear ISR[EOI_LEVEL].
  - Non-specific: clear ISR[HIGHEST_ISR].
  - ISR=0: no effect.
  - EOI is honoured in every state.
- EOI in the same cycle as an ISR set or AEOI clear: the clear applies first, then the set. If the set and clear target the same bit, the set wins.
- A new request cannot be acknowledged during BUSY. Eligibility is re-evaluated in IDLE.
- Reset (async, any state): state=IDLE, ISR=0, IRR_CLR=0, INT=0, DATA_OUT=0, DATA_OE=0, BUSY=0, synchronizer flops=1. A pulse in flight at reset is discarded.
- After reset, INTA_N held low generates no fall edge until it has been seen high.

Test Plan:
- INT_REQ=1, REQ_LEVEL=3, VECTOR_BASE=5'h08, two INTA pulses -> INT=1, then 0 at ACK1. ISR=8'h08, IRR_CLR=8'h08 for one cycle. Second pulse: DATA_OE=1, DATA_OUT=8'h43.
- ISR=8'h04 (level 2 in service), REQ_LEVEL=5 -> INT stays 0. Change REQ_LEVEL to 1 -> INT=1. Acknowledge -> ISR=8'h06.
- AEOI=1, level 6 acknowledged -> ISR bit 6 set after the first pulse, clear after the second pulse's rising edge; ISR ends at 8'h00.
- ISR=8'h41: non-specific EOI -> ISR=8'h40. Then specific EOI with EOI_LEVEL=6 -> ISR=8'h00. EOI with ISR=0 -> no change.
- INT raised, then INT_REQ dropped before INTA -> INT=0. INTA pulses follow -> ISR and IRR_CLR unchanged, DATA_OUT={VECTOR_BASE,3'd7}.
- rst_n asserted during WAIT2 -> all outputs 0 and state IDLE at once. INTA_N held low through reset release -> no acknowledge until a fresh falling edge.
